// File: rtl/imem_arbiter.sv
// imem_arbiter
// Round-robin arbiter that shares one combinational instruction memory
// between NUM_CORES fetch ports. Each fetch takes two cycles: in IDLE the
// winning core's address is registered onto MemAddr, in ISSUE the memory
// word is captured and handed back to that core with a one-cycle strobe.
module imem_arbiter #(
    parameter int NUM_CORES = 8,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 3
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic [NUM_CORES-1:0]        Req,
    input  logic [NUM_CORES*ADDR_W-1:0] ReqAddr,
    output logic [NUM_CORES-1:0]        Grant,
    output logic [NUM_CORES-1:0]        RespValid,
    output logic [DATA_W-1:0]           RespData,
    output logic [ADDR_W-1:0]           MemAddr,
    input  logic [DATA_W-1:0]           MemData,
    output logic                        Busy,
    output logic [IDX_W-1:0]            LastCore
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arbState;

    arbState state, stateNext;

    logic [IDX_W-1:0]     ptr, ptrNext;
    logic [IDX_W-1:0]     win, winNext;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W:0]       cand;
    logic                 found;
    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] grantNext;
    logic [NUM_CORES-1:0] validNext;
    logic [DATA_W-1:0]    dataNext;
    logic [ADDR_W-1:0]    addrNext;
    logic [IDX_W-1:0]     lastNext;

    assign Busy = (state == ISSUE);

    // State and output registers; reset abandons any fetch in flight
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            win       <= '0;
            Grant     <= '0;
            RespValid <= '0;
            RespData  <= '0;
            MemAddr   <= '0;
            LastCore  <= '0;
        end else begin
            state     <= stateNext;
            ptr       <= ptrNext;
            win       <= winNext;
            Grant     <= grantNext;
            RespValid <= validNext;
            RespData  <= dataNext;
            MemAddr   <= addrNext;
            LastCore  <= lastNext;
        end
    end

    // Pick the first eligible core at or after the pointer (wrapping) and decide the next state
    always_comb begin
        eligible  = Req & ~RespValid;
        winner    = '0;
        found     = 1'b0;
        cand      = '0;
        stateNext = state;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_CORES)) begin
                cand = cand - (IDX_W+1)'(NUM_CORES);
            end
            if (!found && eligible[cand[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
        case (state)
            IDLE:    if (found) stateNext = ISSUE;
            ISSUE:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Next values of the registered outputs: issue the winner's address, then capture its instruction
    always_comb begin
        grantNext = '0;
        validNext = '0;
        dataNext  = RespData;
        addrNext  = MemAddr;
        lastNext  = LastCore;
        ptrNext   = ptr;
        winNext   = win;
        case (state)
            IDLE: begin
                if (found) begin
                    addrNext  = ReqAddr[winner*ADDR_W +: ADDR_W];
                    grantNext = NUM_CORES'(1) << winner;
                    winNext   = winner;
                end
            end
            ISSUE: begin
                dataNext  = MemData;
                validNext = NUM_CORES'(1) << win;
                lastNext  = win;
                ptrNext   = (win == IDX_W'(NUM_CORES-1)) ? '0 : win + IDX_W'(1);
            end
            default: begin
                grantNext = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter
// Directed table vectors, hand-written corner sequences and a randomized
// run checked against a cycle-level reference model of the arbiter.
module tb_imem_arbiter;

    localparam int NC         = 8;
    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int IW         = 3;
    localparam int MEMWORDS   = 16384;
    localparam int RANDCYCLES = 3000;
    localparam int NVEC       = 10;

    logic             clk = 1'b0;
    logic             rstN;
    logic [NC-1:0]    req;
    logic [NC*AW-1:0] reqAddr;
    logic [NC-1:0]    grant;
    logic [NC-1:0]    respValid;
    logic [DW-1:0]    respData;
    logic [AW-1:0]    memAddr;
    logic [DW-1:0]    memData;
    logic             busy;
    logic [IW-1:0]    lastCore;

    logic [DW-1:0] mem [0:MEMWORDS-1];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            mPtr;
    int            mWin;
    bit            mBusy;
    logic [NC-1:0] expGrant;
    logic [NC-1:0] expValid;
    logic [DW-1:0] expData;
    logic [AW-1:0] expAddr;
    logic [IW-1:0] expLast;

    typedef struct {
        logic [NC-1:0] req;
        logic [NC-1:0] grant;
        logic [NC-1:0] valid;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          busy;
        logic [IW-1:0] last;
    } vecT;

    vecT vecs [NVEC];

    // Free-running clock
    always #5 clk = ~clk;

    // Combinational instruction memory
    assign memData = mem[memAddr[15:2]];

    imem_arbiter #(
        .NUM_CORES(NC),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .IDX_W    (IW)
    ) dut (
        .Clk      (clk),
        .Rst_n    (rstN),
        .Req      (req),
        .ReqAddr  (reqAddr),
        .Grant    (grant),
        .RespValid(respValid),
        .RespData (respData),
        .MemAddr  (memAddr),
        .MemData  (memData),
        .Busy     (busy),
        .LastCore (lastCore)
    );

    function automatic logic [NC-1:0] onehot(input int i);
        logic [NC-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPtr     = 0;
        mWin     = 0;
        mBusy    = 1'b0;
        expGrant = '0;
        expValid = '0;
        expData  = '0;
        expAddr  = '0;
        expLast  = '0;
    endtask

    // Advance the model by one clock using the inputs presented this cycle
    task automatic modelStep();
        logic [NC-1:0] elig;
        int            pick;
        if (!mBusy) begin
            elig     = req & ~expValid;
            pick     = -1;
            for (int k = 0; k < NC; k++) begin
                if (pick < 0 && elig[(mPtr + k) % NC]) pick = (mPtr + k) % NC;
            end
            expValid = '0;
            expGrant = '0;
            if (pick >= 0) begin
                expGrant = onehot(pick);
                expAddr  = reqAddr[pick*AW +: AW];
                mWin     = pick;
                mBusy    = 1'b1;
            end
        end else begin
            expGrant = '0;
            expData  = mem[expAddr[15:2]];
            expValid = onehot(mWin);
            expLast  = IW'(mWin);
            mPtr     = (mWin + 1) % NC;
            mBusy    = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".Grant"},     32'(grant),     32'(expGrant));
        checkVal({tag, ".RespValid"}, 32'(respValid), 32'(expValid));
        checkVal({tag, ".RespData"},  respData,       expData);
        checkVal({tag, ".MemAddr"},   memAddr,        expAddr);
        checkVal({tag, ".Busy"},      32'(busy),      32'(mBusy));
        checkVal({tag, ".LastCore"},  32'(lastCore),  32'(expLast));
    endtask

    task automatic applyStimulus(input logic [NC-1:0] r);
        req = r;
    endtask

    task automatic setAddr(input int core, input logic [AW-1:0] a);
        reqAddr[core*AW +: AW] = a;
    endtask

    // Let one clock edge happen and land on the following falling edge
    task automatic step();
        modelStep();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < MEMWORDS; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[4] = 32'hDEAD_BEEF;

        // Directed vectors: core 2, then pointer wrap over cores 6, 7, 1 (core 1 unaligned)
        vecs[0] = '{8'h04, 8'h04, 8'h00, 32'h0000_0000, 32'h10, 1'b1, 3'd0};
        vecs[1] = '{8'h04, 8'h00, 8'h04, 32'hDEAD_BEEF, 32'h10, 1'b0, 3'd2};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 32'hDEAD_BEEF, 32'h10, 1'b0, 3'd2};
        vecs[3] = '{8'h40, 8'h40, 8'h00, 32'hDEAD_BEEF, 32'h18, 1'b1, 3'd2};
        vecs[4] = '{8'h40, 8'h00, 8'h40, 32'h1000_0006, 32'h18, 1'b0, 3'd6};
        vecs[5] = '{8'h82, 8'h80, 8'h00, 32'h1000_0006, 32'h1C, 1'b1, 3'd6};
        vecs[6] = '{8'h82, 8'h00, 8'h80, 32'h1000_0007, 32'h1C, 1'b0, 3'd7};
        vecs[7] = '{8'h02, 8'h02, 8'h00, 32'h1000_0007, 32'h13, 1'b1, 3'd7};
        vecs[8] = '{8'h02, 8'h00, 8'h02, 32'hDEAD_BEEF, 32'h13, 1'b0, 3'd1};
        vecs[9] = '{8'h00, 8'h00, 8'h00, 32'hDEAD_BEEF, 32'h13, 1'b0, 3'd1};

        rstN    = 1'b0;
        req     = '0;
        reqAddr = '0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset");

        setAddr(2, 32'h10);
        setAddr(6, 32'h18);
        setAddr(7, 32'h1C);
        setAddr(1, 32'h13);
        rstN = 1'b1;

        for (int v = 0; v < NVEC; v++) begin
            applyStimulus(vecs[v].req);
            step();
            checkVal($sformatf("vec%0d.Grant", v),     32'(grant),     32'(vecs[v].grant));
            checkVal($sformatf("vec%0d.RespValid", v), 32'(respValid), 32'(vecs[v].valid));
            checkVal($sformatf("vec%0d.RespData", v),  respData,       vecs[v].data);
            checkVal($sformatf("vec%0d.MemAddr", v),   memAddr,        vecs[v].addr);
            checkVal($sformatf("vec%0d.Busy", v),      32'(busy),      32'(vecs[v].busy));
            checkVal($sformatf("vec%0d.LastCore", v),  32'(lastCore),  32'(vecs[v].last));
        end

        // All cores requesting from reset release: strict cyclic order
        rstN = 1'b0;
        modelReset();
        for (int i = 0; i < NC; i++) setAddr(i, 32'(4*i));
        applyStimulus('1);
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 0; k < 2*NC; k++) begin
            step();
            checkOutput("all8");
            if (k % 2 == 0) begin
                checkVal("all8.order", 32'(grant), 32'(onehot(k/2)));
            end else begin
                checkVal("all8.resp", 32'(respValid), 32'(onehot(k/2)));
                checkVal("all8.data", respData, mem[k/2]);
                req[k/2] = 1'b0;
            end
        end
        step();
        checkOutput("all8.end");
        checkVal("all8.noRepeat", 32'(grant), 32'h0);

        // Core 3 lingers one cycle past its response while core 5 requests
        setAddr(3, 32'h0C);
        setAddr(5, 32'h14);
        applyStimulus(8'h08);
        step(); checkOutput("hold.g3");
        step(); checkOutput("hold.r3");
        applyStimulus(8'h28);
        step(); checkOutput("hold.g5");
        checkVal("hold.grant5", 32'(grant), 32'h20);
        step(); checkOutput("hold.r5");
        applyStimulus(8'h08);
        step(); checkOutput("hold.again3");
        checkVal("hold.reserve3", 32'(grant), 32'h08);
        step(); checkOutput("hold.r3b");
        applyStimulus(8'h00);
        step(); checkOutput("hold.idle");

        // Asynchronous reset while core 4's fetch is in flight
        setAddr(4, 32'h20);
        setAddr(0, 32'h00);
        applyStimulus(8'h10);
        step(); checkOutput("rst.g4");
        checkVal("rst.grant4", 32'(grant), 32'h10);
        #2 rstN = 1'b0;
        #1;
        checkVal("rst.async.Grant",    32'(grant),     32'h0);
        checkVal("rst.async.Busy",     32'(busy),      32'h0);
        checkVal("rst.async.MemAddr",  memAddr,        32'h0);
        checkVal("rst.async.RespData", respData,       32'h0);
        checkVal("rst.async.LastCore", 32'(lastCore),  32'h0);
        checkVal("rst.async.Valid",    32'(respValid), 32'h0);
        modelReset();
        applyStimulus(8'h11);
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("rst.release");
        step(); checkOutput("rst.g0");
        checkVal("rst.core0first", 32'(grant), 32'h01);
        step(); checkOutput("rst.r0");
        checkVal("rst.noResp4", 32'(respValid), 32'h01);
        applyStimulus(8'h10);
        step(); checkOutput("rst.g4b");
        step(); checkOutput("rst.r4b");
        applyStimulus(8'h00);
        step(); checkOutput("rst.idle");

        // Randomized requesters obeying the hold/drop rules
        for (int c = 0; c < RANDCYCLES; c++) begin
            for (int i = 0; i < NC; i++) begin
                if (expValid[i]) begin
                    if ($urandom_range(1, 0) == 0) begin
                        req[i] = 1'b0;
                    end else begin
                        setAddr(i, $urandom());
                    end
                end else if (req[i]) begin
                    if ($urandom_range(15, 0) == 0) req[i] = 1'b0;
                end else if ($urandom_range(3, 0) == 0) begin
                    setAddr(i, $urandom());
                    req[i] = 1'b1;
                end
            end
            step();
            checkOutput("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
